branch_predict_queue: RTL and testbench
=======================================

# branch_predict_queue

In-flight branch tracking queue between the fetch-stage predictor lookup and commit. Captures each predicted branch's PC and 2-bit saturating-counter value at prediction time, accepts out-of-order resolution by tag, and retires entries in order. Retirement drives the predictor's counter-update port (`CommitedBranchPC`, `BranchTaken`, `BranchCounter`, `CounterUpdate`). A mispredicted branch flushes all younger entries when it retires.

## Interface
- `DEPTH`, 8: entry count; power of two, at least 2.
- `PC_W`, 10: branch PC index width; matches the predictor table index.
- `TAG_W`, $clog2(DEPTH): entry tag width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `PredValid` in 1: fetch presents a predicted branch this cycle.
- `PredPC` in PC_W: PC of that branch.
- `PredCounter` in 2: predictor counter read for `PredPC`.
- `PredReady` out 1: queue can accept; equals ~Full.
- `PredTag` out TAG_W: tag assigned to the entry (tail pointer); meaningful when `PredValid & PredReady`.
- `ResolveValid` in 1: execute reports a branch outcome.
- `ResolveTag` in TAG_W: tag of the resolved branch.
- `ResolveTaken` in 1: actual outcome.
- `CommitedBranchPC` out PC_W: PC of the retired branch.
- `BranchTaken` out 1: actual outcome of the retired branch.
- `BranchCounter` out 2: counter value captured at prediction.
- `CounterUpdate` out 1: one-cycle pulse, retirement valid.
- `Mispredict` out 1: one-cycle pulse coincident with `CounterUpdate`; set when the retired prediction (`BranchCounter[1]`) differs from `BranchTaken`.
- `Empty` out 1: no valid entries.

## Operation
- Each entry holds: `Valid`, `Resolved`, `PC`, `Counter`, `Taken`. State also includes head pointer, tail pointer, and `Count` (TAG_W+1 bits). Pointers wrap modulo DEPTH.
- **Enqueue.** When `PredValid & PredReady`, write the entry at the tail with `Valid=1`, `Resolved=0`, then increment the tail. When `PredValid & ~PredReady`, drop the request with no state change.
- **Resolve.** When `ResolveValid` hits a valid, unresolved entry, set `Resolved=1` and `Taken=ResolveTaken`. A resolve to an invalid or already-resolved entry is ignored.
- **Retire.** When the head entry is `Valid & Resolved` in registered state, pop it: clear `Valid` and increment the head. On the next cycle, drive the registered outputs `CommitedBranchPC`, `BranchTaken`, `BranchCounter`, `CounterUpdate=1`, and `Mispredict`. At most one retirement per cycle.
- **Flush.** When the popping entry is mispredicted (`Counter[1] != Taken`), clear every `Valid`, set tail = head+1 (the new head), and set `Count=0` in the same edge.
  - An enqueue in that cycle is discarded (wrong path).
  - A resolve in that cycle is discarded.
  - Upstream must not send resolves for flushed tags afterwards.
- **Simultaneous events** (no flush):
  - Enqueue and retire in the same cycle: both happen; `Count` is unchanged.
  - Resolve and retire in the same cycle target different entries; both happen.
  - A resolve of the head takes effect on this edge; the head retires on the next edge.
- **Full/empty.** `PredReady` is computed from registered `Count != DEPTH`; it does not look ahead to a same-cycle retire. `Empty = (Count == 0)`.

## Timing
- **Reset.** Pointers and `Count` are 0, all `Valid`/`Resolved` are 0. Outputs: `PredReady=1`, `PredTag=0`, `Empty=1`, `CounterUpdate=0`, `Mispredict=0`, `CommitedBranchPC=0`, `BranchTaken=0`, `BranchCounter=0`.
- **Reset mid-operation.** Discards all entries; no `CounterUpdate` pulse is produced for them.
- `PredTag` and `PredReady` are combinational from registered state.
- **Latency.** Resolve of the head sampled at edge N → pop at edge N+1 → `CounterUpdate` high in the cycle after N+1 → predictor table written at edge N+2.
- **Minimum enqueue-to-retire.** Enqueue at edge E with resolve at edge E+1 → pop at E+2 → `CounterUpdate` high after E+2.
- `CounterUpdate` and `Mispredict` are never high for more than one cycle per retirement. Back-to-back retirements give consecutive pulses.

## Structure
- Package `bpq_pkg` contains:
  - the entry struct (`Valid`, `Resolved`, `PC`, `Counter`, `Taken`);
  - `DEPTH`, `PC_W`, and `TAG_W` defaults;
  - a `mispredicted(counter, taken)` function.
- Sub-module `bpq_ptr`: a wrapping TAG_W pointer with increment and load inputs, instantiated for both head and tail. Everything else stays in the top level.

## Test plan
- **Fill/overflow.** Reset, then 9 enqueues (PCs 0x010..0x018, counter 01) → tags 0..7, `PredReady=0` after the 8th, 9th dropped, `Empty=0`.
- **Out-of-order resolve.** With 3 entries (tags 0,1,2), resolve tag 2 then tag 0, both not-taken → tag 0 retires; `CounterUpdate=1`, `CommitedBranchPC`=tag-0 PC, `BranchCounter=01`, `Mispredict=0`. Tag 2 is held until tag 1 resolves.
- **Mispredict flush.** Tags 0–3 with counter 10; resolve tag 0 with `ResolveTaken=0` → `Mispredict=1`, `Empty=1` afterwards. A same-cycle enqueue is discarded, and the next enqueue gets tag 1.
- **Wrap-around.** Run 20 enqueue/resolve-taken/retire cycles with counter 11 → tags cycle 0..7 repeatedly, in-order `CommitedBranchPC`, no `Mispredict`.
- **Simultaneous enqueue and retire when full.** 8 entries with the head resolved → `PredReady=0` that cycle, head pops, `PredReady=1` the following cycle.
- **Reset mid-flight.** 4 entries, 2 resolved; assert `rst` for 1 cycle → no `CounterUpdate`, all outputs at reset values, next `PredTag=0`.

Source files
------------

// File: rtl/bpq_pkg.sv
// Shared types and defaults for the in-flight branch queue: entry layout,
// size defaults and the misprediction test used at retirement.
package bpq_pkg;

    localparam int BPQ_DEPTH = 8;
    localparam int BPQ_PC_W  = 10;
    localparam int BPQ_TAG_W = $clog2(BPQ_DEPTH);

    typedef struct packed {
        logic                Valid;
        logic                Resolved;
        logic [BPQ_PC_W-1:0] PC;
        logic [1:0]          Counter;
        logic                Taken;
    } entry_t;

    // Counter MSB is the direction the predictor chose.
    function automatic logic mispredicted(input logic [1:0] counter, input logic taken);
        return counter[1] != taken;
    endfunction

endpackage

// File: rtl/bpq_ptr.sv
// Wrapping queue pointer: load wins over increment, wraps modulo 2**TAG_W.
// Single-cycle update; no backpressure of its own.
module bpq_ptr #(
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Inc,
    input  logic             Load,
    input  logic [TAG_W-1:0] LoadValue,
    output logic [TAG_W-1:0] Ptr
);

    localparam logic [TAG_W-1:0] One = 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            Ptr <= '0;
        end else if (Load) begin
            Ptr <= LoadValue;
        end else if (Inc) begin
            Ptr <= Ptr + One;
        end
    end

endmodule

// File: rtl/branch_predict_queue.sv
// In-flight branch tracker: in-order retire to the predictor update port one cycle after pop,
// out-of-order resolve by tag; PredReady drops when full (no look-ahead), mispredict flushes younger entries.
module branch_predict_queue
    import bpq_pkg::*;
#(
    parameter int DEPTH = BPQ_DEPTH,
    parameter int PC_W  = BPQ_PC_W,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PredValid,
    input  logic [PC_W-1:0]  PredPC,
    input  logic [1:0]       PredCounter,
    output logic             PredReady,
    output logic [TAG_W-1:0] PredTag,
    input  logic             ResolveValid,
    input  logic [TAG_W-1:0] ResolveTag,
    input  logic             ResolveTaken,
    output logic [PC_W-1:0]  CommitedBranchPC,
    output logic             BranchTaken,
    output logic [1:0]       BranchCounter,
    output logic             CounterUpdate,
    output logic             Mispredict,
    output logic             Empty
);

    localparam logic [TAG_W:0]   FullCount = (TAG_W + 1)'(DEPTH);
    localparam logic [TAG_W:0]   CountOne  = 1;
    localparam logic [TAG_W-1:0] PtrOne    = 1;

    entry_t           entries [DEPTH];
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [TAG_W:0]   count;

    entry_t           headEntry;
    logic             pop;
    logic             flush;
    logic             enq;
    logic             resolveHit;
    logic [TAG_W-1:0] headPlusOne;

    assign headEntry   = entries[head];
    assign pop         = headEntry.Valid & headEntry.Resolved;
    assign flush       = pop & mispredicted(headEntry.Counter, headEntry.Taken);
    assign PredReady   = (count != FullCount);
    assign PredTag     = tail;
    assign Empty       = (count == '0);
    // Wrong-path traffic arriving alongside a flushing retire is dropped.
    assign enq         = PredValid & PredReady & ~flush;
    assign resolveHit  = ResolveValid & entries[ResolveTag].Valid
                       & ~entries[ResolveTag].Resolved & ~flush;
    assign headPlusOne = head + PtrOne;

    bpq_ptr #(.TAG_W(TAG_W)) u_headPtr (
        .clk       (clk),
        .rst       (rst),
        .Inc       (pop),
        .Load      (1'b0),
        .LoadValue ('0),
        .Ptr       (head)
    );

    // On flush the tail restarts right behind the popped entry, i.e. at the new head.
    bpq_ptr #(.TAG_W(TAG_W)) u_tailPtr (
        .clk       (clk),
        .rst       (rst),
        .Inc       (enq),
        .Load      (flush),
        .LoadValue (headPlusOne),
        .Ptr       (tail)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].Valid    <= 1'b0;
                entries[i].Resolved <= 1'b0;
            end
        end else begin
            // enqueue, resolve and pop never address the same slot in one cycle
            if (enq) begin
                entries[tail] <= '{Valid: 1'b1, Resolved: 1'b0, PC: PredPC,
                                   Counter: PredCounter, Taken: 1'b0};
            end
            if (resolveHit) begin
                entries[ResolveTag].Resolved <= 1'b1;
                entries[ResolveTag].Taken    <= ResolveTaken;
            end
            if (pop) begin
                entries[head].Valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (enq && !pop) begin
            count <= count + CountOne;
        end else if (pop && !enq) begin
            count <= count - CountOne;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            CounterUpdate    <= 1'b0;
            Mispredict       <= 1'b0;
            CommitedBranchPC <= '0;
            BranchTaken      <= 1'b0;
            BranchCounter    <= '0;
        end else begin
            CounterUpdate <= pop;
            Mispredict    <= flush;
            if (pop) begin
                CommitedBranchPC <= headEntry.PC;
                BranchTaken      <= headEntry.Taken;
                BranchCounter    <= headEntry.Counter;
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_queue.sv
// Directed bench for branch_predict_queue: fill, out-of-order resolve, flush,
// wrap-around, full with retire, and mid-flight reset.
module tb_branch_predict_queue;

    localparam int PC_W  = 10;
    localparam int TAG_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             PredValid = 1'b0;
    logic [PC_W-1:0]  PredPC = '0;
    logic [1:0]       PredCounter = '0;
    logic             PredReady;
    logic [TAG_W-1:0] PredTag;
    logic             ResolveValid = 1'b0;
    logic [TAG_W-1:0] ResolveTag = '0;
    logic             ResolveTaken = 1'b0;
    logic [PC_W-1:0]  CommitedBranchPC;
    logic             BranchTaken;
    logic [1:0]       BranchCounter;
    logic             CounterUpdate;
    logic             Mispredict;
    logic             Empty;

    int vecs = 0;
    int errs = 0;

    branch_predict_queue dut (
        .clk              (clk),
        .rst              (rst),
        .PredValid        (PredValid),
        .PredPC           (PredPC),
        .PredCounter      (PredCounter),
        .PredReady        (PredReady),
        .PredTag          (PredTag),
        .ResolveValid     (ResolveValid),
        .ResolveTag       (ResolveTag),
        .ResolveTaken     (ResolveTaken),
        .CommitedBranchPC (CommitedBranchPC),
        .BranchTaken      (BranchTaken),
        .BranchCounter    (BranchCounter),
        .CounterUpdate    (CounterUpdate),
        .Mispredict       (Mispredict),
        .Empty            (Empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        PredValid = 1'b0;
        ResolveValid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic enqueue(input logic [PC_W-1:0] pc, input logic [1:0] ctr);
        PredValid = 1'b1; PredPC = pc; PredCounter = ctr;
        tick();
        PredValid = 1'b0;
    endtask

    task automatic resolve(input logic [TAG_W-1:0] tag, input logic taken);
        ResolveValid = 1'b1; ResolveTag = tag; ResolveTaken = taken;
        tick();
        ResolveValid = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        vecs++; if (PredReady !== 1'b1) begin errs++; $display("FAIL reset_ready got %b exp 1", PredReady); end
        vecs++; if (PredTag !== 3'd0) begin errs++; $display("FAIL reset_tag got %0d exp 0", PredTag); end
        vecs++; if (Empty !== 1'b1) begin errs++; $display("FAIL reset_empty got %b exp 1", Empty); end
        vecs++; if (CounterUpdate !== 1'b0) begin errs++; $display("FAIL reset_cu got %b exp 0", CounterUpdate); end
        vecs++; if (Mispredict !== 1'b0) begin errs++; $display("FAIL reset_mp got %b exp 0", Mispredict); end
        vecs++; if (CommitedBranchPC !== 10'h0) begin errs++; $display("FAIL reset_pc got %0h exp 0", CommitedBranchPC); end
        vecs++; if ({BranchTaken, BranchCounter} !== 3'b000) begin errs++; $display("FAIL reset_tk_ctr got %b exp 000", {BranchTaken, BranchCounter}); end
    endtask

    task automatic test_fill();
        doReset();
        for (int i = 0; i < 9; i++) begin
            PredValid = 1'b1; PredPC = 10'h010 + 10'(i); PredCounter = 2'b01;
            #1;
            vecs++; if (PredReady !== (i < 8)) begin errs++; $display("FAIL fill_ready[%0d] got %b exp %b", i, PredReady, (i < 8)); end
            vecs++; if (PredTag !== 3'(i)) begin errs++; $display("FAIL fill_tag[%0d] got %0d exp %0d", i, PredTag, i % 8); end
            tick();
        end
        PredValid = 1'b0;
        vecs++; if (PredReady !== 1'b0) begin errs++; $display("FAIL fill_full got %b exp 0", PredReady); end
        vecs++; if (Empty !== 1'b0) begin errs++; $display("FAIL fill_empty got %b exp 0", Empty); end
        resolve(3'd0, 1'b0);
        tick();
        vecs++; if (CommitedBranchPC !== 10'h010) begin errs++; $display("FAIL fill_first_pc got %0h exp 010", CommitedBranchPC); end
    endtask

    task automatic test_out_of_order();
        doReset();
        enqueue(10'h100, 2'b01);
        enqueue(10'h101, 2'b01);
        enqueue(10'h102, 2'b01);
        resolve(3'd2, 1'b0);
        resolve(3'd0, 1'b0);
        vecs++; if (CounterUpdate !== 1'b0) begin errs++; $display("FAIL ooo_early_cu got %b exp 0", CounterUpdate); end
        resolve(3'd2, 1'b1);  // duplicate resolve must not overwrite the outcome
        vecs++; if (CounterUpdate !== 1'b1) begin errs++; $display("FAIL ooo_cu0 got %b exp 1", CounterUpdate); end
        vecs++; if (CommitedBranchPC !== 10'h100) begin errs++; $display("FAIL ooo_pc0 got %0h exp 100", CommitedBranchPC); end
        vecs++; if (BranchCounter !== 2'b01) begin errs++; $display("FAIL ooo_ctr0 got %b exp 01", BranchCounter); end
        vecs++; if (Mispredict !== 1'b0) begin errs++; $display("FAIL ooo_mp0 got %b exp 0", Mispredict); end
        tick();
        vecs++; if (CounterUpdate !== 1'b0) begin errs++; $display("FAIL ooo_hold got %b exp 0", CounterUpdate); end
        resolve(3'd1, 1'b0);
        tick();
        vecs++; if ({CounterUpdate, CommitedBranchPC} !== {1'b1, 10'h101}) begin errs++; $display("FAIL ooo_pc1 got %b/%0h exp 1/101", CounterUpdate, CommitedBranchPC); end
        tick();
        vecs++; if ({CounterUpdate, CommitedBranchPC} !== {1'b1, 10'h102}) begin errs++; $display("FAIL ooo_pc2 got %b/%0h exp 1/102", CounterUpdate, CommitedBranchPC); end
        vecs++; if ({BranchTaken, Mispredict} !== 2'b00) begin errs++; $display("FAIL ooo_dup_resolve got tk=%b mp=%b exp 0 0", BranchTaken, Mispredict); end
        tick();
        vecs++; if ({CounterUpdate, Empty} !== 2'b01) begin errs++; $display("FAIL ooo_drain got cu=%b empty=%b exp 0 1", CounterUpdate, Empty); end
    endtask

    task automatic test_flush();
        doReset();
        for (int i = 0; i < 4; i++) enqueue(10'h200 + 10'(i), 2'b10);
        resolve(3'd0, 1'b0);
        PredValid = 1'b1; PredPC = 10'h3FF; PredCounter = 2'b00;
        ResolveValid = 1'b1; ResolveTag = 3'd1; ResolveTaken = 1'b1;
        tick();
        PredValid = 1'b0; ResolveValid = 1'b0;
        vecs++; if ({CounterUpdate, Mispredict} !== 2'b11) begin errs++; $display("FAIL flush_pulse got cu=%b mp=%b exp 1 1", CounterUpdate, Mispredict); end
        vecs++; if (CommitedBranchPC !== 10'h200) begin errs++; $display("FAIL flush_pc got %0h exp 200", CommitedBranchPC); end
        vecs++; if ({BranchTaken, BranchCounter} !== 3'b010) begin errs++; $display("FAIL flush_tk_ctr got %b exp 010", {BranchTaken, BranchCounter}); end
        vecs++; if (Empty !== 1'b1) begin errs++; $display("FAIL flush_empty got %b exp 1", Empty); end
        vecs++; if (PredTag !== 3'd1) begin errs++; $display("FAIL flush_tag got %0d exp 1", PredTag); end
        tick();
        vecs++; if ({CounterUpdate, Mispredict, Empty} !== 3'b001) begin errs++; $display("FAIL flush_after got %b exp 001", {CounterUpdate, Mispredict, Empty}); end
        enqueue(10'h210, 2'b10);
        vecs++; if ({Empty, PredTag} !== {1'b0, 3'd2}) begin errs++; $display("FAIL flush_reenq got empty=%b tag=%0d exp 0 2", Empty, PredTag); end
        resolve(3'd1, 1'b1);
        tick();
        vecs++; if ({CounterUpdate, Mispredict, CommitedBranchPC} !== {2'b10, 10'h210}) begin errs++; $display("FAIL flush_newpath got cu=%b mp=%b pc=%0h exp 1 0 210", CounterUpdate, Mispredict, CommitedBranchPC); end
    endtask

    task automatic test_wrap();
        doReset();
        for (int i = 0; i < 20; i++) begin
            PredValid = 1'b1; PredPC = 10'h300 + 10'(i); PredCounter = 2'b11;
            #1;
            vecs++; if (PredTag !== 3'(i)) begin errs++; $display("FAIL wrap_tag[%0d] got %0d exp %0d", i, PredTag, i % 8); end
            tick();
            PredValid = 1'b0;
            resolve(3'(i), 1'b1);
            tick();
            vecs++; if ({CounterUpdate, Mispredict, CommitedBranchPC} !== {2'b10, 10'h300 + 10'(i)}) begin
                errs++; $display("FAIL wrap_retire[%0d] got cu=%b mp=%b pc=%0h exp 1 0 %0h", i, CounterUpdate, Mispredict, CommitedBranchPC, 10'h300 + 10'(i));
            end
        end
    endtask

    task automatic test_full_retire();
        doReset();
        for (int i = 0; i < 8; i++) enqueue(10'h080 + 10'(i), 2'b00);
        resolve(3'd0, 1'b0);
        PredValid = 1'b1; PredPC = 10'h0AA; PredCounter = 2'b00;
        #1;
        vecs++; if (PredReady !== 1'b0) begin errs++; $display("FAIL full_ready_pop got %b exp 0", PredReady); end
        tick();
        PredValid = 1'b0;
        vecs++; if ({CounterUpdate, CommitedBranchPC} !== {1'b1, 10'h080}) begin errs++; $display("FAIL full_pop got cu=%b pc=%0h exp 1 080", CounterUpdate, CommitedBranchPC); end
        vecs++; if ({PredReady, PredTag} !== {1'b1, 3'd0}) begin errs++; $display("FAIL full_after got rdy=%b tag=%0d exp 1 0", PredReady, PredTag); end
        enqueue(10'h0AA, 2'b00);
        vecs++; if (PredReady !== 1'b0) begin errs++; $display("FAIL full_refill got %b exp 0", PredReady); end
    endtask

    task automatic test_reset_mid();
        doReset();
        for (int i = 0; i < 4; i++) enqueue(10'h040 + 10'(i), 2'b01);
        resolve(3'd1, 1'b0);
        resolve(3'd0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vecs++; if ({CounterUpdate, Mispredict} !== 2'b00) begin errs++; $display("FAIL mid_pulse got %b exp 00", {CounterUpdate, Mispredict}); end
        vecs++; if ({PredReady, PredTag, Empty} !== {1'b1, 3'd0, 1'b1}) begin errs++; $display("FAIL mid_state got rdy=%b tag=%0d empty=%b exp 1 0 1", PredReady, PredTag, Empty); end
        vecs++; if ({CommitedBranchPC, BranchTaken, BranchCounter} !== 13'h0) begin errs++; $display("FAIL mid_outs got %0h exp 0", {CommitedBranchPC, BranchTaken, BranchCounter}); end
        tick();
        vecs++; if ({CounterUpdate, Empty} !== 2'b01) begin errs++; $display("FAIL mid_later got cu=%b empty=%b exp 0 1", CounterUpdate, Empty); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_out_of_order();
        test_flush();
        test_wrap();
        test_full_retire();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
